arm_mcfsm_ws: RTL

Parametrised main control FSM for the multicycle ARM core, replacing the fixed single-cycle-memory sequencer. It drives the same datapath select and enable signals per state. It adds a memory request/ready handshake so fetch, load and store can stretch over any number of wait states. A watchdog forces an error state when memory never responds, and undefined opcodes are trapped. It sits inside `controller`, between the instruction decode fields and the conditional-logic/datapath enables.

---
 rtl/arm_mcfsm_ws_if.sv | 34 +++
 rtl/arm_mcfsm_ws.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/arm_mcfsm_ws_if.sv
// Control bundle between the main FSM and the decode/datapath/memory side.
// Carries the decode fields (Op, Funct), the memory handshake (MemReq/MemReady)
// and all datapath enables, mux selects and debug/status outputs.
interface arm_mcfsm_ws_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       MemReq;
  logic       IRWrite;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       ALUOp;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       BusErr;
  logic       Stall;
  logic [3:0] State;

  modport master (
    input  Op, Funct, MemReady,
    output MemReq, IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc,
           ALUSrcA, ALUSrcB, ResultSrc, BusErr, Stall, State
  );

  modport slave (
    output Op, Funct, MemReady,
    input  MemReq, IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc,
           ALUSrcA, ALUSrcB, ResultSrc, BusErr, Stall, State
  );
endinterface

// File: rtl/arm_mcfsm_ws.sv
// Main control FSM of the multicycle ARM core with wait-state memory handshake,
// a per-access watchdog that traps to ERROR, and undefined-opcode trapping.
// Ports: clk, reset (sync, active-high), bus (arm_mcfsm_ws_if.master).
module arm_mcfsm_ws #(
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  arm_mcfsm_ws_if.master bus
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam bit WDOG_EN = (TIMEOUT > 0);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    ERROR    = 4'd15
  } state_t;

  state_t          state, state_next, out_state;
  logic [CW-1:0]   wait_cnt;
  logic            in_mem, trap, stall;
  logic            unused_funct;

  // Only I (bit 5) and L/S (bit 0) steer the sequencer.
  assign unused_funct = ^bus.Funct[4:1];

  assign in_mem = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign trap   = WDOG_EN && in_mem && !bus.MemReady && (wait_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if ((state_next != state) || bus.MemReady)
        wait_cnt <= '0;
      else if (stall && (wait_cnt != CNT_MAX))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:    if (bus.MemReady) state_next = DECODE;
      DECODE: begin
        case (bus.Op)
          2'b00:   state_next = bus.Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_next = MEMADR;
          2'b10:   state_next = BRANCH;
          default: state_next = ERROR;
        endcase
      end
      MEMADR:   state_next = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD:    if (bus.MemReady) state_next = MEMWB;
      MEMWR:    if (bus.MemReady) state_next = FETCH;
      EXECUTER: state_next = ALUWB;
      EXECUTEI: state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      MEMWB:    state_next = FETCH;
      BRANCH:   state_next = FETCH;
      ERROR:    state_next = ERROR;
      default:  state_next = ERROR;
    endcase
    // Ready beats the watchdog: trap only fires when MemReady is low.
    if (trap) state_next = ERROR;
  end

  // While reset is held the outputs already present a fresh FETCH, so the
  // datapath sees a clean fetch request regardless of the stale state.
  assign out_state = reset ? FETCH : state;

  always_comb begin
    bus.MemReq    = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.NextPC    = 1'b0;
    bus.RegW      = 1'b0;
    bus.MemW      = 1'b0;
    bus.Branch    = 1'b0;
    bus.ALUOp     = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUSrcA   = 2'b00;
    bus.ALUSrcB   = 2'b00;
    bus.ResultSrc = 2'b00;
    bus.BusErr    = 1'b0;
    case (out_state)
      FETCH: begin
        bus.MemReq    = 1'b1;
        bus.ALUSrcA   = 2'b01;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite   = bus.MemReady;
        bus.NextPC    = bus.MemReady;
      end
      DECODE: begin
        bus.ALUSrcA   = 2'b01;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      MEMADR:   bus.ALUSrcB = 2'b01;
      MEMRD: begin
        bus.MemReq = 1'b1;
        bus.AdrSrc = 1'b1;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegW      = 1'b1;
      end
      MEMWR: begin
        bus.MemReq = 1'b1;
        bus.AdrSrc = 1'b1;
        bus.MemW   = 1'b1;
      end
      EXECUTER: bus.ALUOp = 1'b1;
      EXECUTEI: begin
        bus.ALUSrcB = 2'b01;
        bus.ALUOp   = 1'b1;
      end
      ALUWB:    bus.RegW = 1'b1;
      BRANCH: begin
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        bus.Branch    = 1'b1;
      end
      ERROR:    bus.BusErr = 1'b1;
      default:  ;
    endcase
  end

  assign stall     = bus.MemReq & ~bus.MemReady;
  assign bus.Stall = stall;
  assign bus.State = state;

endmodule
